io_uart_controller: RTL and testbench

- Memory-mapped IO slave for the RISC-V core bus. It serves the two IO addresses that the RAM controller deliberately ignores: 0x0000_0FFC (TX data) and 0x0000_1FFC (status).
- Bytes written by the core go into a TX FIFO and are serialised as 8N1 UART on uart_tx.
- Its io_rdata/io_rbusy/io_wbusy are muxed with the RAM controller outputs by the bus decode.

---
 rtl/io_uart_controller_pkg.sv | 21 ++
 rtl/io_uart_controller_if.sv | 21 ++
 rtl/io_uart_controller_sync_fifo.sv | 52 +++++
 rtl/io_uart_controller.sv | 183 ++++++++++++++++++
 tb/tb_io_uart_controller.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_uart_controller_pkg.sv
// Shared types and constants for the IO UART controller: serialiser states,
// default IO addresses and status-register bit positions.
package io_uart_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [31:0] DEF_IO_DATA_ADDR = 32'h0000_0FFC;
  localparam logic [31:0] DEF_IO_STAT_ADDR = 32'h0000_1FFC;

  localparam int unsigned STAT_TX_BUSY = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_PENDING = 3;

endpackage

// File: rtl/io_uart_controller_if.sv
// Core-bus IO slave port: address/data/strobes from the core, read data and
// busy flags back to the bus decode.
interface io_uart_controller_if;
  logic [31:0] riscv_addr;
  logic [31:0] riscv_wdata;
  logic [3:0]  riscv_wmask;
  logic        riscv_rstrb;
  logic [31:0] io_rdata;
  logic        io_rbusy;
  logic        io_wbusy;

  modport master (
    output riscv_addr, riscv_wdata, riscv_wmask, riscv_rstrb,
    input  io_rdata, io_rbusy, io_wbusy
  );

  modport slave (
    input  riscv_addr, riscv_wdata, riscv_wmask, riscv_rstrb,
    output io_rdata, io_rbusy, io_wbusy
  );
endinterface

// File: rtl/io_uart_controller_sync_fifo.sv
// Single-clock circular FIFO with occupancy count. DEPTH must be a power of two;
// push is refused when full and pop when empty.
module io_uart_controller_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_uart_controller.sv
// Memory-mapped UART transmitter: TX data/status registers, write stall via a
// pending byte, and an 8N1 serialiser (8E1 when IO_TX_PARITY_EN is defined).
module io_uart_controller
  import io_uart_controller_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] IO_DATA_ADDR = DEF_IO_DATA_ADDR,
  parameter logic [31:0] IO_STAT_ADDR = DEF_IO_STAT_ADDR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  io_uart_controller_if.slave  bus,
  output logic                 uart_tx,
  output logic                 io_irq
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             pending_q, pending_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_push_data, fifo_pop_data;
  logic [FCW-1:0]   fifo_count;
  logic             wr_req, tx_busy, baud_done;
  logic [31:0]      status;
  logic             unused_bus_bits;

  assign unused_bus_bits = ^{bus.riscv_wdata[31:8], bus.riscv_wmask[3:1]};

  io_uart_controller_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_req  = (bus.riscv_addr == IO_DATA_ADDR) && !bus.riscv_rstrb && bus.riscv_wmask[0];
  assign tx_busy = (state_q != IDLE) || (fifo_count != '0);
  assign io_irq  = (state_q == IDLE) && fifo_empty;

  assign bus.io_rdata = rdata_q;
  assign bus.io_rbusy = 1'b0;
  assign bus.io_wbusy = pending_q;

  // A held pending byte has priority; fresh writes are ignored until it drains.
  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = pend_data_q;
    pending_d      = pending_q;
    pend_data_d    = pend_data_q;
    if (pending_q) begin
      if (!fifo_full) begin
        fifo_push = 1'b1;
        pending_d = 1'b0;
      end
    end else if (wr_req) begin
      if (!fifo_full) begin
        fifo_push      = 1'b1;
        fifo_push_data = bus.riscv_wdata[7:0];
      end else begin
        pending_d   = 1'b1;
        pend_data_d = bus.riscv_wdata[7:0];
      end
    end
  end

  always_comb begin
    status               = '0;
    status[STAT_TX_BUSY] = tx_busy;
    status[STAT_FULL]    = fifo_full;
    status[STAT_EMPTY]   = fifo_empty;
    status[STAT_PENDING] = pending_q;
    rdata_d              = rdata_q;
    if (bus.riscv_rstrb) begin
      if (bus.riscv_addr == IO_STAT_ADDR) begin
        rdata_d = status;
      end else if (bus.riscv_addr == IO_DATA_ADDR) begin
        rdata_d = '0;
      end
    end
  end

  assign baud_done = (baud_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    if (state_q != IDLE) begin
      baud_d = baud_done ? '0 : baud_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_pop_data;
          par_d    = ^fifo_pop_data;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) state_d = DATA;
      end
      DATA: begin
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef IO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_done) state_d = STOP;
      end
      STOP: begin
        if (baud_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift_q[0];
      PARITY:  uart_tx = par_q;
      default: uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      pending_q   <= 1'b0;
      pend_data_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      pending_q   <= pending_d;
      pend_data_q <= pend_data_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_io_uart_controller.sv
// Self-checking bench for io_uart_controller: queue-based transaction model
// compared every cycle, a serial-line receiver, and directed literal checks.
module tb_io_uart_controller;

  localparam int unsigned DIV   = 10;
  localparam int unsigned DEPTH = 4;
`ifdef IO_TX_PARITY_EN
  localparam int unsigned FL = 11 * DIV;
`else
  localparam int unsigned FL = 10 * DIV;
`endif
  localparam logic [31:0] DADDR = 32'h0000_0FFC;
  localparam logic [31:0] SADDR = 32'h0000_1FFC;

  logic clk = 1'b0;
  logic reset_n;
  logic uart_tx, io_irq;
  always #5 clk = ~clk;

  io_uart_controller_if bus ();

  io_uart_controller #(
    .CLK_FREQ_HZ  (1000000),
    .BAUD_RATE    (100000),
    .FIFO_DEPTH   (DEPTH),
    .IO_DATA_ADDR (DADDR),
    .IO_STAT_ADDR (SADDR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .uart_tx (uart_tx),
    .io_irq  (io_irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: byte queue, pending slot, frame timer.
  logic [7:0]  mq[$];
  bit          m_busy, m_pend;
  int          m_t;
  logic [7:0]  m_cur, m_pbyte;
  logic [31:0] m_rdata;

  initial begin
    int n;
    bit full_pre, do_push;
    logic [7:0] pb;
    m_busy = 0; m_pend = 0; m_t = 0; m_rdata = '0; m_cur = '0; m_pbyte = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_busy = 0; m_t = 0; m_pend = 0; m_rdata = '0;
      end else begin
        n = mq.size();
        full_pre = (n == DEPTH);
        if (bus.riscv_rstrb) begin
          if (bus.riscv_addr == SADDR)
            m_rdata = {28'd0, m_pend, n == 0, full_pre, m_busy || n != 0};
          else if (bus.riscv_addr == DADDR)
            m_rdata = '0;
        end
        do_push = 0;
        pb = '0;
        if (m_pend) begin
          if (!full_pre) begin do_push = 1; pb = m_pbyte; m_pend = 0; end
        end else if (bus.riscv_addr == DADDR && !bus.riscv_rstrb && bus.riscv_wmask[0]) begin
          if (!full_pre) begin do_push = 1; pb = bus.riscv_wdata[7:0]; end
          else begin m_pend = 1; m_pbyte = bus.riscv_wdata[7:0]; end
        end
        if (m_busy) begin
          m_t++;
          if (m_t == FL) m_busy = 0;
        end else if (n != 0) begin
          m_cur = mq.pop_front();
          m_busy = 1;
          m_t = 0;
        end
        if (do_push) mq.push_back(pb);
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_t / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
`ifdef IO_TX_PARITY_EN
    if (k == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (en) begin
        check("uart_tx", uart_tx, exp_tx());
        check("io_irq", io_irq, !m_busy && mq.size() == 0);
        check("io_wbusy", bus.io_wbusy, m_pend);
        check("io_rbusy", bus.io_rbusy, 1'b0);
        check("io_rdata", bus.io_rdata, m_rdata);
      end
    end
  end

  // Serial receiver: samples bit centres, logs bytes and start cycles.
  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (en && reset_n && uart_tx === 1'b0) begin
        st = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
`ifdef IO_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
`endif
        repeat (DIV) @(negedge clk);
        rx_bytes.push_back(b);
        rx_start.push_back(st);
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    bus.riscv_addr = addr; bus.riscv_wdata = data; bus.riscv_wmask = mask;
    bus.riscv_rstrb = 1'b0;
    @(negedge clk);
    bus.riscv_addr = '0; bus.riscv_wdata = '0; bus.riscv_wmask = '0;
  endtask

  task automatic read_status(input logic [31:0] exp, input string name);
    bus.riscv_addr = SADDR; bus.riscv_wmask = '0; bus.riscv_rstrb = 1'b1;
    @(negedge clk);
    bus.riscv_addr = '0; bus.riscv_rstrb = 1'b0;
    check(name, bus.io_rdata, exp);
  endtask

  task automatic wait_irq(input int bound, input string name);
    bit ok = 0;
    repeat (bound) begin
      @(negedge clk);
      if (io_irq) begin ok = 1; break; end
    end
    check(name, ok, 1'b1);
  endtask

  logic       a5_seq [10];
  logic [7:0] b2b [6];
  logic [7:0] all_bytes [8];

  initial begin
    bit ok;
    int lows;
    a5_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef IO_TX_PARITY_EN
    a5_seq[9] = 1'b0;
`endif
    b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    all_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h07};
    bus.riscv_addr = '0; bus.riscv_wdata = '0; bus.riscv_wmask = '0; bus.riscv_rstrb = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 en = 1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);

    check("reset_tx", uart_tx, 1'b1);
    check("reset_irq", io_irq, 1'b1);
    check("reset_wbusy", bus.io_wbusy, 1'b0);
    check("reset_rdata", bus.io_rdata, 32'h0);
    read_status(32'h4, "stat_after_reset");

    // Single byte 0xA5, sampled at each bit centre.
    bus_write(DADDR, 32'hA5, 4'b0001);
    repeat (6) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("a5_bit%0d", j), uart_tx, a5_seq[j]);
      if (j < 9) repeat (DIV) @(negedge clk);
    end
    wait_irq(200, "a5_done_timeout");
    check("a5_irq_after", io_irq, 1'b1);

    // Ignored writes.
    bus_write(SADDR, 32'h55, 4'b0001);
    bus_write(DADDR, 32'h66, 4'b0010);
    repeat (3) @(negedge clk);
    read_status(32'h4, "stat_after_ignored");
    check("irq_after_ignored", io_irq, 1'b1);

    // Six back-to-back writes into a 4-deep FIFO.
    for (int i = 0; i < 6; i++) bus_write(DADDR, {24'd0, b2b[i]}, 4'b0001);
    check("stall_wbusy", bus.io_wbusy, 1'b1);
    read_status(32'hB, "stat_stalled");
    ok = 0;
    repeat (300) begin
      @(negedge clk);
      if (!bus.io_wbusy) begin ok = 1; break; end
    end
    check("wbusy_release_timeout", ok, 1'b1);
    wait_irq(1000, "b2b_done_timeout");

    // 0x07 has odd weight: parity bit (or stop bit) at slot 9 is high.
    bus_write(DADDR, 32'h07, 4'b0001);
    repeat (6 + 9 * DIV) @(negedge clk);
    check("b07_slot9", uart_tx, 1'b1);
    wait_irq(200, "b07_done_timeout");
    repeat (2 * DIV) @(negedge clk);

    check("rx_count", rx_bytes.size(), 8);
    for (int i = 0; i < 8 && i < rx_bytes.size(); i++)
      check($sformatf("rx_byte%0d", i), rx_bytes[i], all_bytes[i]);
    for (int i = 1; i < 6 && i + 1 < rx_start.size(); i++)
      check($sformatf("frame_gap%0d", i), rx_start[i+1] - rx_start[i], FL + 1);

    // Reset in the middle of data bit 4.
    bus_write(DADDR, 32'h3C, 4'b0001);
    ok = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_busy && (m_t / DIV) == 5) begin ok = 1; break; end
    end
    check("mid_frame_timeout", ok, 1'b1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1 check("reset_mid_tx", uart_tx, 1'b1);
    check("reset_mid_irq", io_irq, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    read_status(32'h4, "stat_after_mid_reset");
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("no_frame_after_reset", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
